// File: rtl/flash_pkg.sv
// Shared definitions for the flash access arbiter: FSM states, flow and
// grant encodings, and the default timeout length.
package flash_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    COMPLETE  = 3'd4
  } state_t;

  localparam logic FLOW_READ  = 1'b1;
  localparam logic FLOW_WRITE = 1'b0;

  localparam logic GRANT_WR = 1'b0;
  localparam logic GRANT_RD = 1'b1;

  // 20 ms at 50 MHz
  localparam int DEFAULT_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/flash_timeout_timer.sv
// Watchdog counter for one flash operation. Counts while enabled and flags
// the cycle in which the count steps onto TIMEOUT_CYC-1.
module flash_timeout_timer
  import flash_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic CLK_50MHZ,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(TIMEOUT_CYC - 2);

  logic [CNT_W-1:0] count;

  // Count cycles spent waiting on the controller; restart on every new issue
  always_ff @(posedge CLK_50MHZ) begin
    if (RST || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == LAST_STEP);

endmodule

// File: rtl/flash_access_arbiter.sv
// Round-robin arbiter sharing the flash controller between the RS232 write
// path and the display read path. Drives the trigger/status handshake,
// latches read data and flags stalled operations.
module flash_access_arbiter
  import flash_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              CLK_50MHZ,
  input  logic              RST,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] fl_addr,
  output logic [DATA_W-1:0] fl_wdata,
  input  logic [DATA_W-1:0] fl_rdata,
  output logic              fl_flow,
  output logic              fl_trg,
  input  logic              fl_status,
  output logic              err,
  output logic              busy
);

  state_t state, state_n;

  logic              grant, grant_n;
  logic              last_grant, last_grant_n;
  logic              pick;
  logic [ADDR_W-1:0] fl_addr_n;
  logic [DATA_W-1:0] fl_wdata_n;
  logic              fl_flow_n;
  logic [DATA_W-1:0] rd_data_n;
  logic              err_n;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  flash_timeout_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .CLK_50MHZ(CLK_50MHZ),
    .RST      (RST),
    .clr      (timer_clr),
    .en       (timer_en),
    .expired  (timer_expired)
  );

  // State register
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Arbitration, handshake sequencing and next values of the latched outputs
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    pick         = GRANT_WR;
    fl_addr_n    = fl_addr;
    fl_wdata_n   = fl_wdata;
    fl_flow_n    = fl_flow;
    rd_data_n    = rd_data;
    err_n        = err;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;

    case (state)
      IDLE: begin
        if (wr_req && rd_req) begin
          pick = (last_grant == GRANT_WR) ? GRANT_RD : GRANT_WR;
        end else if (rd_req) begin
          pick = GRANT_RD;
        end else begin
          pick = GRANT_WR;
        end
        if (wr_req || rd_req) begin
          grant_n = pick;
          if (pick == GRANT_RD) begin
            fl_addr_n = rd_addr;
            fl_flow_n = FLOW_READ;
          end else begin
            fl_addr_n  = wr_addr;
            fl_wdata_n = wr_data;
            fl_flow_n  = FLOW_WRITE;
          end
          state_n = ISSUE;
        end
      end

      ISSUE: begin
        timer_clr = 1'b1;
        state_n   = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        timer_en = 1'b1;
        if (fl_status) begin
          state_n = WAIT_DONE;
        end else if (timer_expired) begin
          err_n   = 1'b1;
          state_n = COMPLETE;
        end
      end

      WAIT_DONE: begin
        timer_en = 1'b1;
        if (!fl_status) begin
          if (grant == GRANT_RD) begin
            rd_data_n = fl_rdata;
          end
          state_n = COMPLETE;
        end else if (timer_expired) begin
          err_n   = 1'b1;
          state_n = COMPLETE;
        end
      end

      COMPLETE: begin
        last_grant_n = grant;
        state_n      = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered outputs; pulses are decoded from the state being entered
  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      grant      <= GRANT_WR;
      last_grant <= GRANT_WR;
      fl_addr    <= '0;
      fl_wdata   <= '0;
      fl_flow    <= FLOW_READ;
      rd_data    <= '0;
      err        <= 1'b0;
      fl_trg     <= 1'b0;
      wr_ack     <= 1'b0;
      rd_valid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      grant      <= grant_n;
      last_grant <= last_grant_n;
      fl_addr    <= fl_addr_n;
      fl_wdata   <= fl_wdata_n;
      fl_flow    <= fl_flow_n;
      rd_data    <= rd_data_n;
      err        <= err_n;
      fl_trg     <= (state_n == ISSUE);
      wr_ack     <= (state_n == COMPLETE) && (grant_n == GRANT_WR);
      rd_valid   <= (state_n == COMPLETE) && (grant_n == GRANT_RD);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_flash_access_arbiter.sv
// Directed testbench for flash_access_arbiter with a small flash controller
// model that holds busy for a fixed number of cycles or forever.
module tb_flash_access_arbiter;

  logic       CLK_50MHZ;
  logic       RST;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [7:0] fl_addr;
  logic [7:0] fl_wdata;
  logic [7:0] fl_rdata;
  logic       fl_flow;
  logic       fl_trg;
  logic       fl_status;
  logic       err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int   cycleCount = 0;
  int   busyCycles = 3;
  bit   stuckBusy  = 0;
  logic [7:0] modelRdata = 8'h00;

  int   trgCount = 0;
  int   lastTrgCycle = 0;
  logic trgFlow = 1'b1;
  logic [7:0] trgAddr = 8'h00;
  logic [7:0] trgWdata = 8'h00;
  int   wrAckCount = 0;
  int   rdValidCount = 0;
  int   grantLog[$];
  int   pulseLog[$];

  flash_access_arbiter #(
    .ADDR_W     (8),
    .DATA_W     (8),
    .TIMEOUT_CYC(16)
  ) dut (
    .CLK_50MHZ(CLK_50MHZ),
    .RST      (RST),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .fl_addr  (fl_addr),
    .fl_wdata (fl_wdata),
    .fl_rdata (fl_rdata),
    .fl_flow  (fl_flow),
    .fl_trg   (fl_trg),
    .fl_status(fl_status),
    .err      (err),
    .busy     (busy)
  );

  // 50 MHz clock
  initial begin
    CLK_50MHZ = 1'b0;
    forever #10 CLK_50MHZ = ~CLK_50MHZ;
  end

  // Cycle counter used for latency measurements
  always @(posedge CLK_50MHZ) cycleCount <= cycleCount + 1;

  // Flash controller model: busy starts the cycle after fl_trg
  initial begin
    fl_status = 1'b0;
    fl_rdata  = 8'h00;
    forever begin
      @(posedge CLK_50MHZ);
      if (fl_trg === 1'b1) begin
        #1;
        fl_status = 1'b1;
        fl_rdata  = modelRdata;
        if (stuckBusy) begin
          wait (!stuckBusy);
        end else begin
          repeat (busyCycles) @(posedge CLK_50MHZ);
        end
        #1;
        fl_status = 1'b0;
      end
    end
  end

  // Monitor of triggers and completion pulses
  always @(negedge CLK_50MHZ) begin
    if (fl_trg === 1'b1) begin
      trgCount++;
      lastTrgCycle = cycleCount;
      trgFlow  = fl_flow;
      trgAddr  = fl_addr;
      trgWdata = fl_wdata;
      grantLog.push_back(int'(fl_flow));
    end
    if (wr_ack === 1'b1) begin
      wrAckCount++;
      pulseLog.push_back(0);
    end
    if (rd_valid === 1'b1) begin
      rdValidCount++;
      pulseLog.push_back(1);
    end
  end

  // Hard stop in case the sequence stalls somewhere unexpected
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge CLK_50MHZ);
    #1;
  endtask

  task automatic applyStimulus(input logic wrReq, input logic [7:0] wrAddr,
                               input logic [7:0] wrData, input logic rdReq,
                               input logic [7:0] rdAddr);
    wr_req  = wrReq;
    wr_addr = wrAddr;
    wr_data = wrData;
    rd_req  = rdReq;
    rd_addr = rdAddr;
  endtask

  task automatic waitPulse(input bit isRead, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if ((isRead ? rd_valid : wr_ack) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit seen;
    int reqCycle;
    int base;
    int baseWr;
    int baseRd;
    int baseTrg;
    int expFlow[4];

    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    repeat (3) tick();

    // Reset values
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset fl_flow", fl_flow, 1'b1);
    checkOutput("reset fl_trg", fl_trg, 1'b0);
    checkOutput("reset err", err, 1'b0);
    checkOutput("reset fl_addr", fl_addr, 8'h00);
    checkOutput("reset rd_data", rd_data, 8'h00);
    checkOutput("reset acks", {wr_ack, rd_valid}, 2'b00);
    RST = 1'b0;
    repeat (2) tick();

    // Contention straight after reset: reader first, then alternate
    $display("[TB] contention");
    modelRdata = 8'h3E;
    grantLog.delete();
    pulseLog.delete();
    base = wrAckCount + rdValidCount;
    applyStimulus(1'b1, 8'h21, 8'h3C, 1'b1, 8'h22);
    for (int i = 0; i < 200 && (wrAckCount + rdValidCount - base) < 4; i++) tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("contention pulse total", wrAckCount + rdValidCount - base, 4);
    expFlow = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("contention grant %0d", i),
                  (grantLog.size() > i) ? grantLog[i] : 9, expFlow[i]);
      checkOutput($sformatf("contention pulse %0d", i),
                  (pulseLog.size() > i) ? pulseLog[i] : 9, expFlow[i]);
    end
    checkOutput("contention rd_data", rd_data, 8'h3E);
    repeat (3) tick();

    // Write alone
    $display("[TB] write alone");
    baseTrg = trgCount;
    baseWr  = wrAckCount;
    reqCycle = cycleCount;
    applyStimulus(1'b1, 8'hCC, 8'h5A, 1'b0, 8'h00);
    waitPulse(1'b0, 40, seen);
    checkOutput("write ack seen", seen, 1'b1);
    checkOutput("write ack latency", cycleCount - reqCycle, 6);
    checkOutput("write fl_addr held", fl_addr, 8'hCC);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("write trg latency", lastTrgCycle - reqCycle, 1);
    checkOutput("write trg flow", trgFlow, 1'b0);
    checkOutput("write trg addr", trgAddr, 8'hCC);
    checkOutput("write trg wdata", trgWdata, 8'h5A);
    checkOutput("write err", err, 1'b0);
    repeat (5) tick();
    checkOutput("write single trg", trgCount - baseTrg, 1);
    checkOutput("write single ack", wrAckCount - baseWr, 1);

    // Read alone
    $display("[TB] read alone");
    modelRdata = 8'hA7;
    baseRd = rdValidCount;
    reqCycle = cycleCount;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h10);
    waitPulse(1'b1, 40, seen);
    checkOutput("read valid seen", seen, 1'b1);
    checkOutput("read valid latency", cycleCount - reqCycle, 6);
    checkOutput("read data on valid", rd_data, 8'hA7);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("read trg flow", trgFlow, 1'b1);
    checkOutput("read trg addr", trgAddr, 8'h10);
    repeat (10) tick();
    checkOutput("read data held", rd_data, 8'hA7);
    checkOutput("read single valid", rdValidCount - baseRd, 1);

    // Timeout on a read with the controller stuck busy
    $display("[TB] timeout");
    stuckBusy  = 1'b1;
    modelRdata = 8'hEE;
    baseRd = rdValidCount;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h40);
    waitPulse(1'b1, 60, seen);
    checkOutput("timeout valid seen", seen, 1'b1);
    checkOutput("timeout ack after trg", cycleCount - lastTrgCycle, 16);
    checkOutput("timeout err", err, 1'b1);
    checkOutput("timeout rd_data kept", rd_data, 8'hA7);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    stuckBusy = 1'b0;
    repeat (3) tick();
    checkOutput("timeout single valid", rdValidCount - baseRd, 1);

    // A following request is still served and err stays set
    baseWr = wrAckCount;
    applyStimulus(1'b1, 8'h31, 8'h13, 1'b0, 8'h00);
    waitPulse(1'b0, 40, seen);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("post-timeout write ack", seen, 1'b1);
    checkOutput("err sticky", err, 1'b1);
    repeat (3) tick();
    checkOutput("post-timeout single ack", wrAckCount - baseWr, 1);

    // Reset in WAIT_DONE aborts without a pulse
    $display("[TB] reset mid-operation");
    baseWr = wrAckCount;
    applyStimulus(1'b1, 8'h55, 8'hAA, 1'b0, 8'h00);
    repeat (3) tick();
    checkOutput("pre-reset busy", busy, 1'b1);
    RST = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    tick();
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort fl_flow", fl_flow, 1'b1);
    checkOutput("abort err cleared", err, 1'b0);
    RST = 1'b0;
    repeat (6) tick();
    checkOutput("abort no ack", wrAckCount - baseWr, 0);
    reqCycle = cycleCount;
    applyStimulus(1'b1, 8'h77, 8'h99, 1'b0, 8'h00);
    waitPulse(1'b0, 40, seen);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("after-reset write ack", seen, 1'b1);
    checkOutput("after-reset latency", cycleCount - reqCycle, 6);
    checkOutput("after-reset wdata", trgWdata, 8'h99);
    repeat (3) tick();

    // Write request dropped before it could be granted
    $display("[TB] early drop");
    modelRdata = 8'h5C;
    baseTrg = trgCount;
    baseWr  = wrAckCount;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h66);
    repeat (2) tick();
    applyStimulus(1'b1, 8'h88, 8'h44, 1'b1, 8'h66);
    tick();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 8'h66);
    waitPulse(1'b1, 40, seen);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
    checkOutput("drop read valid", seen, 1'b1);
    checkOutput("drop read data", rd_data, 8'h5C);
    repeat (10) tick();
    checkOutput("drop trg count", trgCount - baseTrg, 1);
    checkOutput("drop no wr_ack", wrAckCount - baseWr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_access_arbiter.md
Name: flash_access_arbiter

Overview:
Shares the single flash controller port between two requesters: the RS232 download path (writes) and the scoreboard display reader (reads). Grants one request at a time with round-robin fairness. Sequences the flash trigger/status handshake and latches read data. Reports completion per requester and flags stalled flash operations with a timeout.

Parameters:
ADDR_W, 8, flash address width
DATA_W, 8, flash data width
TIMEOUT_CYC, 1000000, max cycles from fl_trg to operation end (20 ms at 50 MHz); minimum 4

Ports:
CLK_50MHZ  in  1  system clock
RST  in  1  reset
wr_req  in  1  write request, held until wr_ack
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ack  out  1  one-cycle pulse, write finished
rd_req  in  1  read request, held until rd_valid
rd_addr  in  ADDR_W  read address
rd_data  out  DATA_W  read data, valid on rd_valid and held until the next read completes
rd_valid  out  1  one-cycle pulse, read finished
fl_addr  out  ADDR_W  address to flash controller
fl_wdata  out  DATA_W  write data to flash controller
fl_rdata  in  DATA_W  read data from flash controller
fl_flow  out  1  1 = read, 0 = write
fl_trg  out  1  one-cycle start pulse
fl_status  in  1  flash controller busy, high while operation runs
err  out  1  sticky timeout flag, cleared only by RST
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is RST, synchronous, active-high. All outputs are registered. Reset values:
  - wr_ack = rd_valid = fl_trg = err = busy = 0
  - fl_flow = 1 (read, the harmless direction)
  - fl_addr, fl_wdata, rd_data = 0
  - last_grant = WRITE, so the first contended grant goes to the reader.
- RST mid-operation: abort immediately, return to IDLE, no ack or valid pulse.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, COMPLETE.
- IDLE:
  - Neither request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests in the same cycle: grant the requester that is NOT last_grant.
  - On grant, latch fl_addr, fl_wdata (write only) and fl_flow (0 write / 1 read), record grant, go to ISSUE.
- ISSUE: fl_trg = 1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for fl_status = 1, then go to WAIT_DONE. A controller that raises busy in the same cycle as fl_trg is accepted (sampled next cycle).
- WAIT_DONE: wait for fl_status = 0.
  - On read, capture fl_rdata into rd_data in the cycle fl_status is first seen low.
  - Go to COMPLETE.
- Timeout: the counter increments every cycle in WAIT_BUSY and WAIT_DONE. On reaching TIMEOUT_CYC-1, set err = 1 and go to COMPLETE. rd_data is left unchanged on a timed-out read.
- COMPLETE:
  - Pulse wr_ack or rd_valid (granted requester only) for one cycle, including after a timeout.
  - Set last_grant = the granted requester; go to IDLE.
- Latency with an ideal controller (busy for N cycles starting the cycle after fl_trg): request seen in IDLE at cycle t → fl_trg at t+1 → ack/valid at t+N+3.
- Request rules:
  - A request dropped before grant is never served.
  - A request dropped after grant still completes and still pulses its ack.
  - A requester holding req high after its ack is treated as a new request in the next IDLE cycle.
- Back-to-back: the minimum gap between two fl_trg pulses is N+4 cycles. The arbiter never issues fl_trg while not in ISSUE.
- fl_addr, fl_wdata and fl_flow stay stable from ISSUE through COMPLETE.

Decomposition:
- Shared package flash_pkg:
  - state encoding localparams (IDLE=0 … COMPLETE=4)
  - FLOW_READ=1, FLOW_WRITE=0
  - GRANT_WR=0, GRANT_RD=1
  - default TIMEOUT_CYC
- Sub-module flash_timeout_timer:
  - inputs: clr, en
  - output: expired
  - width $clog2(TIMEOUT_CYC)
  - resets to 0 on RST or clr.

Test Plan:
1. Write alone: wr_req=1, wr_addr=8'hCC, wr_data=8'h5A; model busy 3 cycles → fl_trg one cycle with fl_flow=0, fl_addr=CC, fl_wdata=5A; wr_ack exactly 6 cycles after the request; err=0.
2. Read alone: rd_addr=8'h10; model returns 8'hA7 → rd_data=A7 on the rd_valid cycle; rd_data still A7 after 10 idle cycles.
3. Contention: wr_req and rd_req both held → grant order read, write, read, write over 4 operations; each requester sees exactly one pulse per operation.
4. Timeout: TIMEOUT_CYC=16, fl_status held high forever → err=1 and ack pulse 16 cycles after fl_trg; err stays 1 until RST; a following request is still served.
5. Reset mid-operation: RST asserted in WAIT_DONE → next cycle busy=0, fl_flow=1, no ack pulse; a new write after RST completes normally.
6. Early drop: wr_req pulsed for 1 cycle while a read is in progress → no write fl_trg and no wr_ack.
